row_pixel_serializer: RTL

ROW_PIXEL_SERIALIZER -- requirements
Module: row_pixel_serializer

---
 rtl/img_pkg.sv | 22 ++
 rtl/serializer_row_buf.sv | 69 ++++++
 rtl/row_pixel_serializer.sv | 97 +++++++++
 3 files changed

// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  img_pkg
//  Shared pixel/row types and default geometry for the row serializer.
//  Revision: 1.0
// ============================================================================
package img_pkg;

    localparam int PIX_W_DEFAULT = 8;
    localparam int SIZE_DEFAULT  = 100;
    localparam int OUT_W_DEFAULT = SIZE_DEFAULT - 2;

    typedef logic [PIX_W_DEFAULT-1:0] pixel_t;
    typedef pixel_t                   row_t [OUT_W_DEFAULT];

    // Index width that stays legal for a single-element row.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serializer_row_buf.sv
`default_nettype none
// ============================================================================
//  serializer_row_buf
//  Two-entry ping-pong row store with per-row last flags, drained in order.
//  Revision: 1.0
// ============================================================================
module serializer_row_buf
    import img_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEFAULT,
    parameter int PIX_W = PIX_W_DEFAULT,
    parameter int COL_W = idx_width(OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_row [OUT_W],
    input  logic             wr_last,
    input  logic             rd_release,
    input  logic [COL_W-1:0] rd_col,
    output logic [PIX_W-1:0] rd_pix,
    output logic             rd_last,
    output logic [1:0]       occupancy
);

    logic [PIX_W-1:0] mem [2][OUT_W];
    logic [1:0]       last_flag;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            last_flag <= 2'b00;
        end else begin
            if (wr_en) begin
                wr_ptr            <= ~wr_ptr;
                last_flag[wr_ptr] <= wr_last;
            end
            if (rd_release) begin
                rd_ptr <= ~rd_ptr;
            end
            // A write and a release in the same cycle cancel out.
            case ({wr_en, rd_release})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Pixel storage needs no reset: it is only read while its entry is occupied.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < OUT_W; i++) begin
                mem[wr_ptr][i] <= wr_row[i];
            end
        end
    end

    assign rd_pix    = mem[rd_ptr][rd_col];
    assign rd_last   = last_flag[rd_ptr];
    assign occupancy = count;

endmodule
`default_nettype wire

// File: rtl/row_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  row_pixel_serializer
//  Accepts whole filtered rows and streams them out one pixel per handshake.
//  Revision: 1.0
// ============================================================================
module row_pixel_serializer
    import img_pkg::*;
#(
    parameter int SIZE  = SIZE_DEFAULT,
    parameter int PIX_W = PIX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [PIX_W-1:0] row_in [SIZE-2],
    input  logic             row_last,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_sol,
    output logic             pix_eol,
    output logic             pix_eof,
    output logic [15:0]      pix_row
);

    localparam int               OUT_W    = SIZE - 2;
    localparam int               COL_W    = idx_width(OUT_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);

    logic [COL_W-1:0] col;
    logic [15:0]      row_cnt;
    logic [1:0]       occupancy;
    logic [PIX_W-1:0] rd_pix;
    logic             rd_last;
    logic             accept;
    logic             at_eol;
    logic             pix_fire;
    logic             release_row;

    // Ready depends only on stored occupancy, so it never waits on a same-cycle drain.
    assign row_ready   = rst_n && (occupancy != 2'd2);
    assign accept      = row_valid && row_ready;
    assign at_eol      = (col == COL_LAST);
    assign pix_fire    = pix_valid && pix_ready;
    assign release_row = pix_fire && at_eol;

    serializer_row_buf #(
        .OUT_W (OUT_W),
        .PIX_W (PIX_W),
        .COL_W (COL_W)
    ) u_row_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (accept),
        .wr_row     (row_in),
        .wr_last    (row_last),
        .rd_release (release_row),
        .rd_col     (col),
        .rd_pix     (rd_pix),
        .rd_last    (rd_last),
        .occupancy  (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col     <= '0;
            row_cnt <= 16'd0;
        end else if (pix_fire) begin
            if (at_eol) begin
                col     <= '0;
                row_cnt <= rd_last ? 16'd0 : row_cnt + 16'd1;
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_comb begin
        pix_valid = rst_n && (occupancy != 2'd0);
        pix_data  = '0;
        pix_sol   = 1'b0;
        pix_eol   = 1'b0;
        pix_eof   = 1'b0;
        if (pix_valid) begin
            pix_data = rd_pix;
            pix_sol  = (col == '0);
            pix_eol  = at_eol;
            pix_eof  = at_eol && rd_last;
        end
    end

    assign pix_row = rst_n ? row_cnt : 16'd0;

endmodule
`default_nettype wire
